// File: rtl/i2c_txn_sequencer.sv
// Register-access sequencer driving a byte-level I2C master through START/WRITE/RESTART/READ/STOP.
// Optional NACK retry is enabled by defining I2C_SEQ_RETRY_EN.
module i2c_txn_sequencer #(
    parameter int RETRIES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic       req_rw,
    input  logic [6:0] req_dev,
    input  logic [7:0] req_reg,
    input  logic [7:0] req_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_err,
    output logic [2:0] m_cmd,
    output logic [7:0] m_din,
    output logic       m_wr_i2c,
    input  logic       m_ready,
    input  logic       m_done_tick,
    input  logic       m_ack,
    input  logic [7:0] m_dout
);
    localparam logic [2:0] CMD_START   = 3'b000;
    localparam logic [2:0] CMD_WRITE   = 3'b001;
    localparam logic [2:0] CMD_READ    = 3'b010;
    localparam logic [2:0] CMD_STOP    = 3'b011;
    localparam logic [2:0] CMD_RESTART = 3'b100;

`ifdef I2C_SEQ_RETRY_EN
    localparam bit RETRY_EN = 1'b1;
`else
    localparam bit RETRY_EN = 1'b0;
`endif

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_RESP} state_t;

    state_t     state;
    logic [2:0] step;
    logic       rw;
    logic [6:0] dev;
    logic [7:0] reg_addr;
    logic [7:0] wdata;
    logic       nack;
    logic [1:0] retry_cnt;

    logic [2:0] step_cmd;
    logic [7:0] step_din;
    logic [2:0] stop_step;

    // Command table: write uses steps 0..4, read uses steps 0..6.
    always_comb begin
        step_cmd  = CMD_STOP;
        step_din  = 8'h00;
        stop_step = rw ? 3'd6 : 3'd4;
        case (step)
            3'd0: step_cmd = CMD_START;
            3'd1: begin step_cmd = CMD_WRITE; step_din = {dev, 1'b0}; end
            3'd2: begin step_cmd = CMD_WRITE; step_din = reg_addr; end
            3'd3: begin
                if (rw) step_cmd = CMD_RESTART;
                else begin step_cmd = CMD_WRITE; step_din = wdata; end
            end
            3'd4: if (rw) begin step_cmd = CMD_WRITE; step_din = {dev, 1'b1}; end
            3'd5: begin step_cmd = CMD_READ; step_din = 8'h01; end
            default: step_cmd = CMD_STOP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            step      <= 3'd0;
            rw        <= 1'b0;
            dev       <= 7'h00;
            reg_addr  <= 8'h00;
            wdata     <= 8'h00;
            nack      <= 1'b0;
            retry_cnt <= 2'd0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= 8'h00;
            rsp_err   <= 1'b0;
            m_cmd     <= CMD_START;
            m_din     <= 8'h00;
            m_wr_i2c  <= 1'b0;
        end else begin
            m_wr_i2c  <= 1'b0;
            rsp_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_valid && req_ready) begin
                        rw        <= req_rw;
                        dev       <= req_dev;
                        reg_addr  <= req_reg;
                        wdata     <= req_wdata;
                        step      <= 3'd0;
                        nack      <= 1'b0;
                        retry_cnt <= 2'd0;
                        req_ready <= 1'b0;
                        state     <= S_ISSUE;
                    end else begin
                        req_ready <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    if (m_ready) begin
                        m_cmd    <= step_cmd;
                        m_din    <= step_din;
                        m_wr_i2c <= 1'b1;
                        state    <= S_GUARD;
                    end
                end
                // Master needs a cycle to drop m_ready after the strobe.
                S_GUARD: state <= S_WAIT;
                S_WAIT: begin
                    if (m_cmd == CMD_WRITE || m_cmd == CMD_READ) begin
                        if (m_done_tick) begin
                            state <= S_ISSUE;
                            if (m_cmd == CMD_READ) begin
                                rsp_rdata <= m_dout;
                                step      <= step + 3'd1;
                            end else begin
                                nack <= nack | m_ack;
                                step <= m_ack ? stop_step : step + 3'd1;
                            end
                        end
                    end else if (m_ready) begin
                        if (m_cmd == CMD_STOP) begin
                            if (RETRY_EN && nack && (int'(retry_cnt) < RETRIES)) begin
                                retry_cnt <= retry_cnt + 2'd1;
                                nack      <= 1'b0;
                                step      <= 3'd0;
                                state     <= S_ISSUE;
                            end else begin
                                rsp_valid <= 1'b1;
                                rsp_err   <= nack;
                                state     <= S_RESP;
                            end
                        end else begin
                            step  <= step + 3'd1;
                            state <= S_ISSUE;
                        end
                    end
                end
                S_RESP: begin
                    req_ready <= 1'b1;
                    state     <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Directed bench for i2c_txn_sequencer: vector table of transactions against a simple I2C master model,
// plus hand sequences for reset, busy-hold and mid-transaction reset.
module tb_i2c_txn_sequencer;
    typedef logic [11:0][10:0] seq_t;
    typedef struct {
        logic       rw;
        logic [6:0] dev;
        logic [7:0] rg;
        logic [7:0] wd;
        logic [7:0] rb;
        int         nacks;
        int         n;
        seq_t       seq;
        logic       err;
        logic [7:0] rdata;
    } vec_t;

    localparam logic [10:0] ST = {3'd0, 8'h00};
    localparam logic [10:0] SP = {3'd3, 8'h00};
    localparam logic [10:0] RS = {3'd4, 8'h00};
    localparam logic [10:0] RD = {3'd2, 8'h01};

    logic clk = 1'b0, reset = 1'b1;
    logic req_valid = 1'b0, req_ready, req_rw = 1'b0;
    logic [6:0] req_dev = 7'h00;
    logic [7:0] req_reg = 8'h00, req_wdata = 8'h00;
    logic rsp_valid, rsp_err;
    logic [7:0] rsp_rdata;
    logic [2:0] m_cmd;
    logic [7:0] m_din;
    logic m_wr_i2c, m_ready;
    logic m_done_tick = 1'b0, m_ack = 1'b0;
    logic [7:0] m_dout = 8'h00;

    // master model state
    logic hold = 1'b0, rdy_int = 1'b1, nk = 1'b0;
    logic [2:0] cur = 3'd3;
    int cnt = 0, viol = 0, n_log = 0, addr_seen = 0, nack_limit = 0;
    logic [7:0] rbyte = 8'h00;
    logic [10:0] log_q [0:255];

    int nvec = 0, nerr = 0;
    vec_t tbl [0:6];
    vec_t v;

    always #5 clk = ~clk;

    i2c_txn_sequencer #(.RETRIES(2)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_rw(req_rw), .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .m_cmd(m_cmd), .m_din(m_din), .m_wr_i2c(m_wr_i2c), .m_ready(m_ready),
        .m_done_tick(m_done_tick), .m_ack(m_ack), .m_dout(m_dout)
    );

    assign m_ready = rdy_int & ~hold;

    // Master: 3-cycle busy time per command; NACKs the first address byte after
    // START while addr_seen < nack_limit.
    always @(posedge clk) begin
        m_done_tick <= 1'b0;
        if (reset) begin
            rdy_int <= 1'b1;
            cnt     <= 0;
            cur     <= 3'd3;
        end else begin
            if (m_wr_i2c && !m_ready) viol <= viol + 1;
            if (m_wr_i2c && m_ready) begin
                log_q[n_log[7:0]] <= {m_cmd, m_din};
                n_log   <= n_log + 1;
                cur     <= m_cmd;
                cnt     <= 3;
                rdy_int <= 1'b0;
                nk      <= (m_cmd == 3'd1) && (cur == 3'd0) && (addr_seen < nack_limit);
                if (m_cmd == 3'd1 && cur == 3'd0) addr_seen <= addr_seen + 1;
            end else if (cnt > 0) begin
                cnt <= cnt - 1;
                if (cnt == 1) begin
                    rdy_int <= 1'b1;
                    if (cur == 3'd1 || cur == 3'd2) begin
                        m_done_tick <= 1'b1;
                        m_ack       <= (cur == 3'd1) ? nk : 1'b0;
                        m_dout      <= rbyte;
                    end
                end
            end
        end
    end

    function automatic logic [10:0] W(input logic [7:0] d);
        return {3'd1, d};
    endfunction

    function automatic vec_t mkv(input logic rw, input logic [6:0] dev, input logic [7:0] rg, wd, rb,
                                 input int nacks, n, input seq_t seq, input logic err, input logic [7:0] rdata);
        vec_t t;
        t.rw = rw; t.dev = dev; t.rg = rg; t.wd = wd; t.rb = rb;
        t.nacks = nacks; t.n = n; t.seq = seq; t.err = err; t.rdata = rdata;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic run_txn(input vec_t t, input int hold_cyc, input string nm);
        int base;
        bit seen;
        seen = 0;
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        chk({nm, "_idle"}, 32'(req_ready), 32'd1);
        base = n_log;
        nack_limit = addr_seen + t.nacks;
        rbyte = t.rb;
        hold = (hold_cyc > 0);
        req_rw = t.rw; req_dev = t.dev; req_reg = t.rg; req_wdata = t.wd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk({nm, "_ready_drop"}, 32'(req_ready), 32'd0);
        if (hold_cyc == 0) begin
            @(negedge clk);
            chk({nm, "_first_strobe"}, {28'd0, m_wr_i2c, m_cmd}, {28'd0, 1'b1, 3'd0});
        end else begin
            for (int i = 0; i < hold_cyc; i++) begin
                chk({nm, "_hold_quiet"}, {30'd0, m_wr_i2c, req_ready}, 32'd0);
                req_valid = (i % 2 == 0);
                req_dev = 7'h01; req_reg = 8'hEE; req_rw = 1'b1;
                @(negedge clk);
            end
            req_valid = 1'b0;
            hold = 1'b0;
        end
        for (int i = 0; i < 3000; i++) begin
            if (rsp_valid) begin seen = 1; break; end
            @(negedge clk);
        end
        chk({nm, "_rsp_seen"}, 32'(seen), 32'd1);
        if (seen) begin
            chk({nm, "_err"}, 32'(rsp_err), 32'(t.err));
            chk({nm, "_rdata"}, 32'(rsp_rdata), 32'(t.rdata));
            @(negedge clk);
            chk({nm, "_rsp_pulse"}, {30'd0, rsp_valid, req_ready}, 32'd1);
        end
        chk({nm, "_nstrobes"}, 32'(n_log - base), 32'(t.n));
        for (int k = 0; k < t.n && k < 12; k++)
            chk($sformatf("%s_strobe%0d", nm, k), 32'(log_q[8'(base + k)]), 32'(t.seq[t.n - 1 - k]));
    endtask

    initial begin
        int snap;
        bit hit;
        tbl[0] = mkv(0, 7'h50, 8'h10, 8'hA5, 8'h00, 0, 5, seq_t'({ST, W(8'hA0), W(8'h10), W(8'hA5), SP}), 0, 8'h00);
        tbl[1] = mkv(1, 7'h50, 8'h20, 8'h00, 8'h3C, 0, 7, seq_t'({ST, W(8'hA0), W(8'h20), RS, W(8'hA1), RD, SP}), 0, 8'h3C);
        tbl[2] = mkv(0, 7'h3A, 8'hFF, 8'h00, 8'h00, 0, 5, seq_t'({ST, W(8'h74), W(8'hFF), W(8'h00), SP}), 0, 8'h3C);
`ifdef I2C_SEQ_RETRY_EN
        tbl[3] = mkv(0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, 8,
                     seq_t'({ST, W(8'hA0), SP, ST, W(8'hA0), W(8'h10), W(8'hA5), SP}), 0, 8'h3C);
        tbl[4] = mkv(1, 7'h11, 8'h22, 8'h00, 8'h5A, 1, 10,
                     seq_t'({ST, W(8'h22), SP, ST, W(8'h22), W(8'h22), RS, W(8'h23), RD, SP}), 0, 8'h5A);
        tbl[5] = mkv(0, 7'h50, 8'h10, 8'hA5, 8'h00, 3, 9,
                     seq_t'({ST, W(8'hA0), SP, ST, W(8'hA0), SP, ST, W(8'hA0), SP}), 1, 8'h5A);
`else
        tbl[3] = mkv(0, 7'h50, 8'h10, 8'hA5, 8'h00, 1, 3, seq_t'({ST, W(8'hA0), SP}), 1, 8'h3C);
        tbl[4] = mkv(1, 7'h11, 8'h22, 8'h00, 8'h5A, 1, 3, seq_t'({ST, W(8'h22), SP}), 1, 8'h3C);
        tbl[5] = mkv(0, 7'h50, 8'h10, 8'hA5, 8'h00, 3, 3, seq_t'({ST, W(8'hA0), SP}), 1, 8'h3C);
`endif
        tbl[6] = mkv(1, 7'h7F, 8'h00, 8'h00, 8'hFF, 0, 7, seq_t'({ST, W(8'hFE), W(8'h00), RS, W(8'hFF), RD, SP}), 0, 8'hFF);

        // reset state
        repeat (3) @(negedge clk);
        chk("reset_outs", {8'd0, req_ready, rsp_valid, rsp_err, rsp_rdata, m_wr_i2c, m_cmd, m_din}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 7; i++) run_txn(tbl[i], 0, $sformatf("vec%0d", i));

        // busy hold: m_ready low for 20 cycles from accept, stray requests ignored
        v = tbl[0];
        v.rdata = 8'hFF;
        run_txn(v, 20, "hold");
        snap = n_log;
        repeat (30) @(negedge clk);
        chk("hold_no_extra", 32'(n_log - snap), 32'd0);

        // reset during the write-data step
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        nack_limit = addr_seen;
        req_rw = 1'b0; req_dev = 7'h50; req_reg = 8'h10; req_wdata = 8'hC3;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        hit = 0;
        for (int i = 0; i < 200; i++) begin
            if (m_wr_i2c && m_cmd == 3'd1 && m_din == 8'hC3) begin hit = 1; break; end
            @(negedge clk);
        end
        chk("mid_reset_reach_data", 32'(hit), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_reset_outs", {8'd0, req_ready, rsp_valid, rsp_err, rsp_rdata, m_wr_i2c, m_cmd, m_din}, 32'd0);
        snap = n_log;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_ready", 32'(req_ready), 32'd1);
        repeat (10) @(negedge clk);
        chk("mid_reset_no_stop", 32'(n_log - snap), 32'd0);

        run_txn(tbl[1], 0, "post_reset");
        chk("ready_protocol", 32'(viol), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
